// File: rtl/bus_frame_receiver.sv
// Receive side of the single-wire node bus: deserializes 80-bit frames, checks
// framing and CRC-4, filters on node address, and holds accepted frames for the node.
//
// state  | meaning
// IDLE   | waiting for a start bit (only once armed)
// HDR    | shifting src addr, receiver addr, mod (10 bits)
// DATA   | shifting 64 data bits
// CRC    | shifting the 4 received CRC bits
// STOP   | sampling the stop bit and evaluating the frame
module bus_frame_receiver #(
  parameter logic [3:0] NODE_ADDR = 4'd0,
  parameter logic [3:0] CRC_POLY  = 4'b0011
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        bus,
  input  logic        rx_ready,
  output logic        rx_valid,
  output logic [63:0] rx_data,
  output logic [3:0]  rx_src_addr,
  output logic [1:0]  rx_mod,
  output logic        crc_err,
  output logic        frame_err,
  output logic        overrun,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_DATA = 3'd2,
    S_CRC  = 3'd3,
    S_STOP = 3'd4
  } state_t;

  state_t      state_q;
  logic [6:0]  cnt_q;
  logic        armed_q;
  logic [3:0]  crc_q;
  logic [3:0]  crc_d;
  logic [3:0]  crc_rx_q;
  logic [9:0]  hdr_q;
  logic [63:0] data_q;

  logic        rx_valid_q;
  logic [63:0] rx_data_q;
  logic [3:0]  rx_src_addr_q;
  logic [1:0]  rx_mod_q;
  logic        crc_err_q;
  logic        frame_err_q;
  logic        overrun_q;
  logic        busy_q;

  function automatic logic [3:0] crc_step(input logic [3:0] crc, input logic din);
    logic fb;
    fb = crc[3] ^ din;
    return {crc[2:0], 1'b0} ^ (fb ? CRC_POLY : 4'h0);
  endfunction

  assign crc_d = crc_step(crc_q, bus);

  logic [3:0] f_src;
  logic [3:0] f_rcv;
  logic [1:0] f_mod;
  logic       stop_bad;
  logic       crc_bad;
  logic       mod_bad;
  logic       own_frame;
  logic       addressed;
  logic       accept;
  logic       hold_free;

  assign f_src     = hdr_q[9:6];
  assign f_rcv     = hdr_q[5:2];
  assign f_mod     = hdr_q[1:0];
  assign stop_bad  = ~bus;
  assign crc_bad   = (crc_q != crc_rx_q);
  assign mod_bad   = f_mod[1];
  assign own_frame = (f_src == NODE_ADDR);
  assign addressed = ((f_mod == 2'd0) && (f_rcv == NODE_ADDR)) || (f_mod == 2'd1);
  assign accept    = ~stop_bad & ~crc_bad & ~mod_bad & ~own_frame & addressed;
  // A consume on the same edge frees the slot for the incoming frame.
  assign hold_free = ~rx_valid_q | rx_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= 7'd0;
      armed_q       <= 1'b0;
      crc_q         <= 4'h0;
      crc_rx_q      <= 4'h0;
      hdr_q         <= 10'd0;
      data_q        <= 64'd0;
      rx_valid_q    <= 1'b0;
      rx_data_q     <= 64'd0;
      rx_src_addr_q <= 4'd0;
      rx_mod_q      <= 2'd0;
      crc_err_q     <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      crc_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;

      if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          if (bus) begin
            armed_q <= 1'b1;
          end else if (armed_q) begin
            state_q <= S_HDR;
            cnt_q   <= 7'd0;
            crc_q   <= 4'h0;
            busy_q  <= 1'b1;
          end
        end

        S_HDR: begin
          hdr_q <= {hdr_q[8:0], bus};
          crc_q <= crc_d;
          if (cnt_q == 7'd9) begin
            state_q <= S_DATA;
            cnt_q   <= 7'd0;
          end else begin
            cnt_q <= cnt_q + 7'd1;
          end
        end

        S_DATA: begin
          data_q <= {data_q[62:0], bus};
          crc_q  <= crc_d;
          if (cnt_q == 7'd63) begin
            state_q <= S_CRC;
            cnt_q   <= 7'd0;
          end else begin
            cnt_q <= cnt_q + 7'd1;
          end
        end

        S_CRC: begin
          crc_rx_q <= {crc_rx_q[2:0], bus};
          if (cnt_q == 7'd3) begin
            state_q <= S_STOP;
            cnt_q   <= 7'd0;
          end else begin
            cnt_q <= cnt_q + 7'd1;
          end
        end

        S_STOP: begin
          state_q <= S_IDLE;
          cnt_q   <= 7'd0;
          busy_q  <= 1'b0;
          if (stop_bad) begin
            frame_err_q <= 1'b1;
          end else if (crc_bad) begin
            crc_err_q <= 1'b1;
          end else if (mod_bad) begin
            frame_err_q <= 1'b1;
          end else if (accept) begin
            if (hold_free) begin
              rx_valid_q    <= 1'b1;
              rx_data_q     <= data_q;
              rx_src_addr_q <= f_src;
              rx_mod_q      <= f_mod;
            end else begin
              overrun_q <= 1'b1;
            end
          end
        end

        default: begin
          state_q <= S_IDLE;
          cnt_q   <= 7'd0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rx_valid    = rx_valid_q;
  assign rx_data     = rx_data_q;
  assign rx_src_addr = rx_src_addr_q;
  assign rx_mod      = rx_mod_q;
  assign crc_err     = crc_err_q;
  assign frame_err   = frame_err_q;
  assign overrun     = overrun_q;
  assign busy        = busy_q;

endmodule

// File: doc/bus_frame_receiver.md
Name: bus_frame_receiver

Overview:
- Receive side of the shared single-wire node bus.
- Each node samples the bus once per clock and deserializes one frame. The frame carries source address, receiver address, mode, 64-bit data and CRC-4.
- The block checks framing and CRC, then filters on its own node address.
- An accepted frame is presented on a valid/ready holding register to the node logic.

Parameters:
- NODE_ADDR, 4'd0, this node's 4-bit address
- CRC_POLY, 4'b0011, CRC-4 polynomial x^4+x+1, implicit x^4 term

Ports:
- clock  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- bus  in  1  serial bus line, synchronous to clock, idle high
- rx_ready  in  1  node logic consumes the held frame
- rx_valid  out  1  held frame available
- rx_data  out  64  received Data
- rx_src_addr  out  4  sender addr
- rx_mod  out  2  received mod field
- crc_err  out  1  one-cycle pulse: CRC mismatch
- frame_err  out  1  one-cycle pulse: bad stop bit or reserved mod
- overrun  out  1  one-cycle pulse: accepted frame dropped because holding register full
- busy  out  1  frame reception in progress

Behaviour:
- Frame layout: 80 bits, sampled one per clock, MSB first within each field.
  - start(0)
  - src addr[3:0]
  - receiver addr[3:0]
  - mod[1:0]
  - data[63:0]
  - crc[3:0]
  - stop(1)
- CRC:
  - Serial LFSR, init 4'h0, covers the 74 bits from src addr through data.
  - Per bit: fb = crc[3]^bit; crc = {crc[2:0],1'b0} ^ (fb ? CRC_POLY : 4'h0).
  - The received crc field must equal the register value after the 74th bit.
- Reset: all outputs 0, all state IDLE, CRC reg 0, holding register empty, armed=0.
- armed:
  - Set once bus is sampled 1 in IDLE.
  - A start bit is recognised only when armed=1.
  - This prevents locking onto a frame already in flight at reset release.
- States:
  - IDLE: bus==0 && armed → HDR, counter=0, crc cleared.
  - HDR: 10 bits (src, rcv, mod) → DATA.
  - DATA: 64 bits → CRC.
  - CRC: 4 bits → STOP.
  - STOP: 1 bit → IDLE.
- Counter is 7 bits and reloads to 0 at each state change.
- busy=1 in every state except IDLE.
- Timing:
  - Start bit sampled at edge E0; payload bit k sampled at edge E0+k+1; stop bit sampled at E0+79.
  - All results (rx_valid, pulses) update on edge E0+79.
  - The next start bit may be sampled at E0+80: back-to-back frames with no idle gap are supported, and armed stays 1.
- Evaluation at the stop edge, first match wins:
  1. stop==0 → frame_err.
  2. CRC mismatch → crc_err.
  3. mod ∈ {2,3} → frame_err.
  4. src==NODE_ADDR → silently dropped (own transmission).
  5. mod==0 and rcv==NODE_ADDR, or mod==1 (broadcast) → accept.
  6. Otherwise → silently dropped.
- Error pulses fire for every frame on the bus, whatever its address.
- Holding register handshake:
  - On accept with rx_valid==0: load rx_data/rx_src_addr/rx_mod, set rx_valid.
  - rx_valid && rx_ready clears rx_valid on that edge. Fields keep their last values.
  - Accept while rx_valid==1 and rx_ready==0: new frame discarded, old held, overrun pulse.
  - Accept on the same edge as rx_valid && rx_ready: new frame loads, rx_valid stays 1, no overrun.
- Reset mid-frame: the frame is abandoned with no pulses; armed=0.
- Outputs are registered; no combinational path from bus or rx_ready to any output.

Test Plan:
- Reset, bus=1 for 5 cycles; frame src=0, rcv=1, mod=0, data=64'h1, correct CRC, NODE_ADDR=1 → busy high 79 cycles; rx_valid=1 at E0+79; rx_data=1, rx_src_addr=0, rx_mod=0.
- Same frame with CRC bit 0 flipped → crc_err single pulse at E0+79; rx_valid stays 0.
- Broadcast: src=2, rcv=5, mod=1, data=64'hDEADBEEF_00000001, good CRC → accepted. Same frame with mod=0 → no output, no pulse.
- Stop bit=0 → frame_err pulse only. Reserved mod=3 with good CRC → frame_err pulse. src==NODE_ADDR → nothing.
- Two back-to-back good frames, rx_ready=0 → first held, overrun pulse at second stop edge. Repeat with rx_ready=1 on the second stop edge → second frame loaded, rx_valid continuous.
- Assert reset_n low at bit 30 of a frame, release with bus=0 mid-frame → no start detected until bus returns 1. Next complete frame received correctly.
